// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the register-file/ALU datapath: latches one instruction per handshake and steps IDLE/OPA/OPB/WB.
// Optional retired-instruction counter enabled by defining CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter  int NREG = 8,
  parameter  int OPW  = 4,
  localparam int AW   = $clog2(NREG),
  localparam int IW   = 2*AW + OPW + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic            eni,
  output logic            ens,
  output logic            enc,
  output logic [NREG-1:0] en,
  output logic [AW-1:0]   mux_sel,
  output logic [OPW-1:0]  alu_sel,
  output logic            mode,
  output logic            wb_src,
  output logic            done
`ifdef CTRL_PERF_EN
  ,
  output logic [15:0]     insn_count
`endif
);

  typedef enum logic [1:0] {IDLE, OPA, OPB, WB} state_t;
  typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_MOV = 2'b01, CLS_NOP = 2'b10, CLS_RSV = 2'b11} cls_t;

  state_t          state_q;
  logic [IW-1:0]   ir_q;

  logic [AW-1:0]   ir_rx;
  logic [AW-1:0]   ir_ry;
  logic [OPW-1:0]  ir_op;
  logic            ir_mode;
  cls_t            ir_cls;
  cls_t            in_cls;
  logic            accept;

  assign ir_rx   = ir_q[IW-1 -: AW];
  assign ir_ry   = ir_q[IW-AW-1 -: AW];
  assign ir_op   = ir_q[3 +: OPW];
  assign ir_mode = ir_q[2];
  assign ir_cls  = cls_t'(ir_q[1:0]);
  assign in_cls  = cls_t'(instr[1:0]);

  assign accept = (state_q == IDLE) && run && instr_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else if (run) begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= (in_cls == CLS_ALU) ? OPA : WB;
          end
        end
        OPA:     state_q <= OPB;
        OPB:     state_q <= WB;
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    instr_ready = 1'b0;
    eni         = 1'b0;
    ens         = 1'b0;
    enc         = 1'b0;
    en          = '0;
    mux_sel     = '0;
    alu_sel     = '0;
    mode        = 1'b0;
    wb_src      = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = run;
        eni         = accept && !rst;
      end
      OPA: begin
        ens     = run;
        mux_sel = ir_rx;
      end
      OPB: begin
        enc     = run;
        mux_sel = ir_ry;
        alu_sel = ir_op;
        mode    = ir_mode;
      end
      WB: begin
        done = run;
        case (ir_cls)
          CLS_ALU: en[ir_rx] = run;
          CLS_MOV: begin
            en[ir_rx] = run;
            mux_sel   = ir_ry;
            wb_src    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [15:0] insn_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       insn_count_q <= '0;
    else if (done) insn_count_q <= insn_count_q + 16'd1;
  end

  assign insn_count = insn_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default NREG=8/OPW=4 plus a NREG=16/OPW=5 instance).
// Inputs change 1 time unit after the rising edge; combinational outputs are checked 1 unit later.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [12:0] instr;
  logic        instr_valid;
  logic        instr_ready, eni, ens, enc, mode, wb_src, done;
  logic [7:0]  en;
  logic [2:0]  mux_sel;
  logic [3:0]  alu_sel;

  logic [15:0] instr2;
  logic        instr_valid2;
  logic        instr_ready2, eni2, ens2, enc2, mode2, wb_src2, done2;
  logic [15:0] en2;
  logic [3:0]  mux_sel2;
  logic [4:0]  alu_sel2;
`ifdef CTRL_PERF_EN
  logic [15:0] insn_count, insn_count2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .eni(eni), .ens(ens), .enc(enc), .en(en),
    .mux_sel(mux_sel), .alu_sel(alu_sel), .mode(mode), .wb_src(wb_src), .done(done)
`ifdef CTRL_PERF_EN
    , .insn_count(insn_count)
`endif
  );

  multicycle_ctrl #(.NREG(16), .OPW(5)) dut16 (
    .clk(clk), .rst(rst), .run(run), .instr(instr2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .eni(eni2), .ens(ens2), .enc(enc2), .en(en2),
    .mux_sel(mux_sel2), .alu_sel(alu_sel2), .mode(mode2), .wb_src(wb_src2), .done(done2)
`ifdef CTRL_PERF_EN
    , .insn_count(insn_count2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] mk(input logic [2:0] rx, input logic [2:0] ry,
                                     input logic [3:0] op, input logic md, input logic [1:0] cls);
    return {rx, ry, op, md, cls};
  endfunction

  // Offer an instruction in the current (IDLE) cycle and check the accept strobe.
  task automatic offer(input logic [12:0] word, input string tag);
    instr       = word;
    instr_valid = 1'b1;
    #1;
    check({tag, "_eni"}, 32'(eni), 32'd1);
    tick();
    instr_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; instr = '0; instr_valid = 1'b0;
    instr2 = '0; instr_valid2 = 1'b0;
    #2;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_en", 32'(en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mux", 32'(mux_sel), 32'd0);
    run = 1'b0; #1;
    check("rst_ready_run0", 32'(instr_ready), 32'd0);
    run = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;

    // ALU rx=3 ry=5 op=A mode=1; instr altered during OPA must not matter.
    offer(mk(3'd3, 3'd5, 4'hA, 1'b1, 2'b00), "alu");
    check("alu_opa_ens", 32'(ens), 32'd1);
    check("alu_opa_mux", 32'(mux_sel), 32'd3);
    check("alu_opa_ready", 32'(instr_ready), 32'd0);
    instr = mk(3'd6, 3'd1, 4'h2, 1'b0, 2'b01); instr_valid = 1'b1;
    #1;
    check("alu_opa_eni_ignored", 32'(eni), 32'd0);
    tick();
    instr_valid = 1'b0; #1;
    check("alu_opb_enc", 32'(enc), 32'd1);
    check("alu_opb_mux", 32'(mux_sel), 32'd5);
    check("alu_opb_alu", 32'(alu_sel), 32'hA);
    check("alu_opb_mode", 32'(mode), 32'd1);
    check("alu_opb_ens", 32'(ens), 32'd0);
    tick();
    check("alu_wb_en", 32'(en), 32'h08);
    check("alu_wb_src", 32'(wb_src), 32'd0);
    check("alu_wb_done", 32'(done), 32'd1);
    check("alu_wb_mode", 32'(mode), 32'd0);
    tick();
    check("alu_idle_ready", 32'(instr_ready), 32'd1);
    check("alu_idle_done", 32'(done), 32'd0);

    // MOV rx=7 ry=2
    offer(mk(3'd7, 3'd2, 4'h0, 1'b0, 2'b01), "mov");
    check("mov_wb_en", 32'(en), 32'h80);
    check("mov_wb_mux", 32'(mux_sel), 32'd2);
    check("mov_wb_src", 32'(wb_src), 32'd1);
    check("mov_wb_done", 32'(done), 32'd1);
    tick();
    check("mov_idle_ready", 32'(instr_ready), 32'd1);

    // NOP and reserved class
    offer(mk(3'd4, 3'd1, 4'h3, 1'b1, 2'b10), "nop");
    check("nop_wb_en", 32'(en), 32'd0);
    check("nop_wb_done", 32'(done), 32'd1);
    tick();
    check("nop_idle_ready", 32'(instr_ready), 32'd1);
    offer(mk(3'd4, 3'd1, 4'h3, 1'b1, 2'b11), "rsv");
    check("rsv_wb_en", 32'(en), 32'd0);
    check("rsv_wb_done", 32'(done), 32'd1);
    check("rsv_wb_src", 32'(wb_src), 32'd0);
    tick();

    // Stall in IDLE: no accept while run=0
    run = 1'b0; instr = mk(3'd1, 3'd1, 4'h1, 1'b0, 2'b01); instr_valid = 1'b1;
    #1;
    check("idle_stall_ready", 32'(instr_ready), 32'd0);
    check("idle_stall_eni", 32'(eni), 32'd0);
    tick();
    run = 1'b1; instr_valid = 1'b0; #1;
    check("idle_stall_held", 32'(instr_ready), 32'd1);
    check("idle_stall_no_wb", 32'(done), 32'd0);

    // Stall three cycles in OPB
    offer(mk(3'd3, 3'd5, 4'hA, 1'b1, 2'b00), "stl");
    tick();
    run = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("stl_enc", 32'(enc), 32'd0);
      check("stl_mux", 32'(mux_sel), 32'd5);
      check("stl_alu", 32'(alu_sel), 32'hA);
      check("stl_done", 32'(done), 32'd0);
      tick();
    end
    run = 1'b1; #1;
    check("stl_resume_enc", 32'(enc), 32'd1);
    tick();
    check("stl_wb_done", 32'(done), 32'd1);
    check("stl_wb_en", 32'(en), 32'h08);
    tick();
    check("stl_after_done", 32'(done), 32'd0);
    check("stl_after_ready", 32'(instr_ready), 32'd1);

    // Reset mid-OPB aborts the instruction
    offer(mk(3'd3, 3'd5, 4'hA, 1'b1, 2'b00), "rmid");
    tick();
    check("rmid_opb_enc", 32'(enc), 32'd1);
    rst = 1'b1; #1;
    check("rmid_enc", 32'(enc), 32'd0);
    check("rmid_alu", 32'(alu_sel), 32'd0);
    check("rmid_ready", 32'(instr_ready), 32'd1);
    tick();
    rst = 1'b0; #1;
    check("rmid_rel_ready", 32'(instr_ready), 32'd1);
    check("rmid_rel_done", 32'(done), 32'd0);
    tick();
    check("rmid_no_done", 32'(done), 32'd0);
    check("rmid_no_en", 32'(en), 32'd0);

`ifdef CTRL_PERF_EN
    check("perf_zero", 32'(insn_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      offer(mk(3'd0, 3'd0, 4'h0, 1'b0, 2'b10), "perf");
      tick();
    end
    check("perf_three", 32'(insn_count), 32'd3);
`endif

    // NREG=16, OPW=5 instance: MOV rx=15 ry=9, then ALU rx=15 op=0x1F
    instr2 = {4'd15, 4'd9, 5'd0, 1'b0, 2'b01}; instr_valid2 = 1'b1;
    #1;
    check("w16_eni", 32'(eni2), 32'd1);
    tick();
    instr_valid2 = 1'b0; #1;
    check("w16_mov_en", 32'(en2), 32'h8000);
    check("w16_mov_mux", 32'(mux_sel2), 32'd9);
    check("w16_mov_done", 32'(done2), 32'd1);
    tick();
    instr2 = {4'd15, 4'd2, 5'h1F, 1'b1, 2'b00}; instr_valid2 = 1'b1;
    #1;
    tick();
    instr_valid2 = 1'b0; #1;
    check("w16_opa_mux", 32'(mux_sel2), 32'd15);
    tick();
    check("w16_opb_alu", 32'(alu_sel2), 32'h1F);
    tick();
    check("w16_alu_en", 32'(en2), 32'h8000);
    check("w16_alu_done", 32'(done2), 32'd1);
    tick();
    check("w16_idle_ready", 32'(instr_ready2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
